rc_f2c_responder: RTL and testbench



---
 rtl/rc_f2c_responder.sv | 217 +++++++++++++++++++++
 tb/tb_rc_f2c_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_f2c_responder.sv
// rc_f2c_responder
//   Target end of the ring protocol. Every ring slot is snooped. RD/WR
//   requests addressed to this core, and WR_BCAST packets from other cores,
//   are accepted into a small F2C buffer. They are performed one at a time on
//   the local memory/CR port, and read data returns to the ring as RD_RSP
//   packets. Anything not consumed here passes through with one cycle of
//   latency.
//
// Ports
//   QClk, RstQnnnH        clock, synchronous active-high reset
//   CoreID                local core id, matched against address[31:24]
//   RingIn*               incoming ring slot (valid/opcode/address/data/requestor)
//   RingOut*              registered outgoing ring slot
//   F2cReq*               local access request (RD or WR), held while not ready
//   F2cRspValid/Data      in-order read data return from the local port
//   RcError               one-cycle pulse: lost broadcast write or orphan response
module rc_f2c_responder #(
    parameter int F2C_ENTRIESNUM = 4,
    parameter int REQ_ID_W       = 10
) (
    input  logic                QClk,
    input  logic                RstQnnnH,
    input  logic [7:0]          CoreID,
    input  logic                RingInValid,
    input  logic [1:0]          RingInOpcode,
    input  logic [31:0]         RingInAddress,
    input  logic [31:0]         RingInData,
    input  logic [REQ_ID_W-1:0] RingInRequestor,
    output logic                RingOutValid,
    output logic [1:0]          RingOutOpcode,
    output logic [31:0]         RingOutAddress,
    output logic [31:0]         RingOutData,
    output logic [REQ_ID_W-1:0] RingOutRequestor,
    output logic                F2cReqValid,
    output logic [1:0]          F2cReqOpcode,
    output logic [31:0]         F2cReqAddress,
    output logic [31:0]         F2cReqData,
    input  logic                F2cReqReady,
    input  logic                F2cRspValid,
    input  logic [31:0]         F2cRspData,
    output logic                RcError
);

    localparam int IDX_W = (F2C_ENTRIESNUM > 1) ? $clog2(F2C_ENTRIESNUM) : 1;

    localparam logic [1:0] OP_RD       = 2'b00;
    localparam logic [1:0] OP_RD_RSP   = 2'b01;
    localparam logic [1:0] OP_WR       = 2'b10;
    localparam logic [1:0] OP_WR_BCAST = 2'b11;

    typedef enum logic [2:0] {
        E_FREE, E_WRITE, E_READ, E_READ_PRGRS, E_READ_RDY
    } entry_state_e;

    typedef enum logic [1:0] {RING_INPUT, F2C_RESPONSE, BUBBLE_OUT} out_sel_e;

    typedef struct packed {
        logic [1:0]          opcode;
        logic [31:0]         address;
        logic [31:0]         data;
        logic [REQ_ID_W-1:0] requestor;
    } entry_t;

    typedef struct packed {
        logic                valid;
        logic [1:0]          opcode;
        logic [31:0]         address;
        logic [31:0]         data;
        logic [REQ_ID_W-1:0] requestor;
    } ring_pkt_t;

    entry_state_e          state_q [F2C_ENTRIESNUM];
    entry_state_e          state_d [F2C_ENTRIESNUM];
    entry_t                entry_q [F2C_ENTRIESNUM];
    entry_t                entry_d [F2C_ENTRIESNUM];
    ring_pkt_t             ring_out_q, ring_out_d;
    logic                  rc_error_q, rc_error_d;
    // Issue lock: keeps F2cReq* on the same entry until the port accepts it,
    // even if a lower-index entry becomes pending in the meantime.
    logic                  hold_q, hold_d;
    logic [IDX_W-1:0]      hold_idx_q, hold_idx_d;

    // Lowest-index searches over the current entry states.
    logic                  free_found, rdy_found, pend_found, any_prgrs;
    logic [IDX_W-1:0]      free_idx, rdy_idx, pend_idx, prgrs_idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_found = 1'b0; free_idx  = '0;
        rdy_found  = 1'b0; rdy_idx   = '0;
        pend_found = 1'b0; pend_idx  = '0;
        any_prgrs  = 1'b0; prgrs_idx = '0;
        for (int i = 0; i < F2C_ENTRIESNUM; i++) begin
            if (!free_found && state_q[i] == E_FREE) begin
                free_found = 1'b1; free_idx = IDX_W'(i);
            end
            if (!rdy_found && state_q[i] == E_READ_RDY) begin
                rdy_found = 1'b1; rdy_idx = IDX_W'(i);
            end
            if (!pend_found && (state_q[i] == E_WRITE || state_q[i] == E_READ)) begin
                pend_found = 1'b1; pend_idx = IDX_W'(i);
            end
            if (!any_prgrs && state_q[i] == E_READ_PRGRS) begin
                any_prgrs = 1'b1; prgrs_idx = IDX_W'(i);
            end
        end
    end

    // Ring input decode. Core id 0 is never a local target.
    logic in_core_match, local_hit, bcast, bcast_own, bcast_foreign, alloc, consumed;

    assign in_core_match = (RingInAddress[31:24] == CoreID) && (CoreID != 8'h00);
    assign local_hit     = RingInValid && in_core_match &&
                           (RingInOpcode == OP_RD || RingInOpcode == OP_WR);
    assign bcast         = RingInValid && (RingInOpcode == OP_WR_BCAST);
    assign bcast_own     = bcast && (RingInRequestor[REQ_ID_W-1 -: 8] == CoreID);
    assign bcast_foreign = bcast && !bcast_own;
    assign alloc         = (local_hit || bcast_foreign) && free_found;
    // A broadcast from another core is copied locally but still travels on,
    // so only a buffered hit or our own returning broadcast frees the slot.
    assign consumed      = (local_hit && free_found) || bcast_own;

    logic             issue_valid;
    logic [IDX_W-1:0] issue_idx;
    out_sel_e         out_sel;

    assign issue_valid = hold_q || (!any_prgrs && pend_found);
    assign issue_idx   = hold_q ? hold_idx_q : pend_idx;

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        ring_out_d = '0;
        rc_error_d = 1'b0;
        hold_d     = issue_valid && !F2cReqReady;
        hold_idx_d = issue_idx;

        if (issue_valid && F2cReqReady) begin
            state_d[issue_idx] = (state_q[issue_idx] == E_WRITE) ? E_FREE : E_READ_PRGRS;
        end

        // Issue and response are mutually exclusive: issue needs no READ_PRGRS
        // entry, a response needs one.
        if (F2cRspValid) begin
            if (any_prgrs) begin
                state_d[prgrs_idx]      = E_READ_RDY;
                entry_d[prgrs_idx].data = F2cRspData;
            end else begin
                rc_error_d = 1'b1;
            end
        end

        if (alloc) begin
            state_d[free_idx] = (local_hit && RingInOpcode == OP_RD) ? E_READ : E_WRITE;
            entry_d[free_idx] = '{opcode:    bcast ? OP_WR : RingInOpcode,
                                  address:   RingInAddress,
                                  data:      RingInData,
                                  requestor: RingInRequestor};
        end
        if (bcast_foreign && !free_found) begin
            rc_error_d = 1'b1;
        end

        if (RingInValid && !consumed) out_sel = RING_INPUT;
        else if (rdy_found)           out_sel = F2C_RESPONSE;
        else                          out_sel = BUBBLE_OUT;

        case (out_sel)
            RING_INPUT: ring_out_d = '{valid: 1'b1, opcode: RingInOpcode,
                                       address: RingInAddress, data: RingInData,
                                       requestor: RingInRequestor};
            F2C_RESPONSE: begin
                ring_out_d = '{valid: 1'b1, opcode: OP_RD_RSP,
                               address: entry_q[rdy_idx].address,
                               data: entry_q[rdy_idx].data,
                               requestor: entry_q[rdy_idx].requestor};
                state_d[rdy_idx] = E_FREE;
            end
            default: ring_out_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            for (int i = 0; i < F2C_ENTRIESNUM; i++) state_q[i] <= E_FREE;
            ring_out_q <= '0;
            rc_error_q <= 1'b0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ring_out_q <= ring_out_d;
            rc_error_q <= rc_error_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // NOTE: entry payload is not reset; it is only observed through a non-FREE state.
    always_ff @(posedge QClk) begin
        entry_q <= entry_d;
    end

    assign RingOutValid     = ring_out_q.valid;
    assign RingOutOpcode    = ring_out_q.opcode;
    assign RingOutAddress   = ring_out_q.address;
    assign RingOutData      = ring_out_q.data;
    assign RingOutRequestor = ring_out_q.requestor;
    assign RcError          = rc_error_q;

    assign F2cReqValid   = issue_valid;
    assign F2cReqOpcode  = issue_valid ? entry_q[issue_idx].opcode  : 2'b00;
    assign F2cReqAddress = issue_valid ? entry_q[issue_idx].address : 32'h0;
    assign F2cReqData    = issue_valid ? entry_q[issue_idx].data    : 32'h0;

endmodule

// File: tb/tb_rc_f2c_responder.sv
module tb_rc_f2c_responder;

    localparam logic [1:0] RD = 2'b00, RD_RSP = 2'b01, WR = 2'b10, WR_BCAST = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [9:0]  req;
    } pkt_t;

    logic        QClk = 1'b0;
    logic        RstQnnnH;
    logic [7:0]  CoreID;
    logic        RingInValid;
    logic [1:0]  RingInOpcode;
    logic [31:0] RingInAddress, RingInData;
    logic [9:0]  RingInRequestor;
    logic        RingOutValid;
    logic [1:0]  RingOutOpcode;
    logic [31:0] RingOutAddress, RingOutData;
    logic [9:0]  RingOutRequestor;
    logic        F2cReqValid;
    logic [1:0]  F2cReqOpcode;
    logic [31:0] F2cReqAddress, F2cReqData;
    logic        F2cReqReady;
    logic        F2cRspValid = 1'b0;
    logic [31:0] F2cRspData = 32'h0;
    logic        RcError;

    always #5 QClk = ~QClk;

    rc_f2c_responder dut (
        .QClk(QClk), .RstQnnnH(RstQnnnH), .CoreID(CoreID),
        .RingInValid(RingInValid), .RingInOpcode(RingInOpcode),
        .RingInAddress(RingInAddress), .RingInData(RingInData),
        .RingInRequestor(RingInRequestor),
        .RingOutValid(RingOutValid), .RingOutOpcode(RingOutOpcode),
        .RingOutAddress(RingOutAddress), .RingOutData(RingOutData),
        .RingOutRequestor(RingOutRequestor),
        .F2cReqValid(F2cReqValid), .F2cReqOpcode(F2cReqOpcode),
        .F2cReqAddress(F2cReqAddress), .F2cReqData(F2cReqData),
        .F2cReqReady(F2cReqReady), .F2cRspValid(F2cRspValid),
        .F2cRspData(F2cRspData), .RcError(RcError)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    pkt_t exp_q[$];
    logic [31:0] rd_data_q[$];
    bit   mon_en    = 1'b0;
    bit   mem_hold  = 1'b0;
    bit   force_rsp = 1'b0;
    bit   rsp_next  = 1'b0;
    logic [31:0] rsp_next_data = 32'h0;

    // Memory model: a read accepted in cycle K returns data during cycle K+1.
    always @(negedge QClk) begin
        F2cRspValid = rsp_next | force_rsp;
        F2cRspData  = rsp_next_data;
        rsp_next    = 1'b0;
        if (RstQnnnH === 1'b0 && F2cReqValid === 1'b1 && F2cReqReady === 1'b1 &&
            F2cReqOpcode === RD && !mem_hold) begin
            rsp_next      = 1'b1;
            rsp_next_data = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 32'hBAD0_BAD0;
        end
    end

    // Scoreboard: every valid ring output must be the next expected packet.
    always @(negedge QClk) begin
        if (mon_en && RingOutValid === 1'b1) begin
            pkt_t got;
            got = {RingOutOpcode, RingOutAddress, RingOutData, RingOutRequestor};
            n_checks++;
            assert (exp_q.size() != 0)
            else begin
                n_errors++;
                $error("FAIL ring_unexpected: observed=%h expected=<none>", got);
            end
            if (exp_q.size() != 0) begin
                pkt_t exp;
                exp = exp_q.pop_front();
                n_checks++;
                assert (got === exp)
                else begin
                    n_errors++;
                    $error("FAIL ring_pkt: observed=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge QClk);
        #1;
    endtask

    function automatic pkt_t mk(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [9:0] r);
        return pkt_t'({op, a, d, r});
    endfunction

    task automatic drive(input pkt_t p);
        RingInValid     = 1'b1;
        RingInOpcode    = p.op;
        RingInAddress   = p.addr;
        RingInData      = p.data;
        RingInRequestor = p.req;
    endtask

    task automatic idle();
        RingInValid     = 1'b0;
        RingInOpcode    = 2'b00;
        RingInAddress   = 32'h0;
        RingInData      = 32'h0;
        RingInRequestor = 10'h0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pkt_t p;
        RstQnnnH    = 1'b1;
        CoreID      = 8'h03;
        F2cReqReady = 1'b1;
        idle();
        repeat (3) tick();
        chk("reset_ringout_valid", 64'(RingOutValid), 64'd0);
        chk("reset_ringout_addr",  64'(RingOutAddress), 64'd0);
        chk("reset_ringout_data",  64'(RingOutData), 64'd0);
        chk("reset_req_valid",     64'(F2cReqValid), 64'd0);
        chk("reset_rc_error",      64'(RcError), 64'd0);
        RstQnnnH = 1'b0;
        mon_en   = 1'b1;
        tick();

        // Pass-through to a foreign core.
        p = mk(RD, 32'h0500_0020, 32'h1111_2222, 10'h01C);
        drive(p); exp_q.push_back(p);
        tick();
        chk("pass_valid",     64'(RingOutValid), 64'd1);
        chk("pass_addr",      64'(RingOutAddress), 64'h0500_0020);
        chk("pass_no_req",    64'(F2cReqValid), 64'd0);
        idle(); tick();
        chk("pass_no_req_2",  64'(F2cReqValid), 64'd0);

        // Local read: request at N+1, RD_RSP on the ring at N+4.
        rd_data_q.push_back(32'hDEAD_BEEF);
        drive(mk(RD, 32'h0340_0010, 32'h0, 10'h015));
        exp_q.push_back(mk(RD_RSP, 32'h0340_0010, 32'hDEAD_BEEF, 10'h015));
        tick();
        chk("lrd_consumed",   64'(RingOutValid), 64'd0);
        chk("lrd_req_valid",  64'(F2cReqValid), 64'd1);
        chk("lrd_req_op",     64'(F2cReqOpcode), 64'(RD));
        chk("lrd_req_addr",   64'(F2cReqAddress), 64'h0340_0010);
        idle(); tick();
        chk("lrd_single_outstanding", 64'(F2cReqValid), 64'd0);
        tick();
        chk("lrd_n3_no_rsp",  64'(RingOutValid), 64'd0);
        tick();
        chk("lrd_n4_valid",   64'(RingOutValid), 64'd1);
        chk("lrd_n4_opcode",  64'(RingOutOpcode), 64'(RD_RSP));
        chk("lrd_n4_data",    64'(RingOutData), 64'hDEAD_BEEF);
        tick();

        // Local write: request the next cycle.
        drive(mk(WR, 32'h0300_0044, 32'hCAFE_0001, 10'h00C));
        tick();
        chk("lwr_req_valid",  64'(F2cReqValid), 64'd1);
        chk("lwr_req_op",     64'(F2cReqOpcode), 64'(WR));
        chk("lwr_req_data",   64'(F2cReqData), 64'hCAFE_0001);
        chk("lwr_consumed",   64'(RingOutValid), 64'd0);
        idle(); tick();
        chk("lwr_retired",    64'(F2cReqValid), 64'd0);

        // Full buffer: four reads fill it, the fifth goes round again.
        F2cReqReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_data_q.push_back(32'hA000_0000 + 32'(i));
            drive(mk(RD, 32'h0300_0100 + 32'(4 * i), 32'h0, 10'h020 + 10'(i)));
            tick();
            chk("full_consumed", 64'(RingOutValid), 64'd0);
            chk("full_no_error", 64'(RcError), 64'd0);
        end
        p = mk(RD, 32'h0300_0110, 32'h0, 10'h024);
        drive(p); exp_q.push_back(p);
        tick();
        chk("full_fwd_valid", 64'(RingOutValid), 64'd1);
        chk("full_fwd_addr",  64'(RingOutAddress), 64'h0300_0110);
        chk("full_req_held",  64'(F2cReqAddress), 64'h0300_0100);
        idle();
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(RD_RSP, 32'h0300_0100 + 32'(4 * i),
                               32'hA000_0000 + 32'(i), 10'h020 + 10'(i)));
        tick();
        chk("full_no_error_2", 64'(RcError), 64'd0);
        F2cReqReady = 1'b1;
        drain("full_drain", 60);

        // Broadcast from another core: forwarded and written locally.
        p = mk(WR_BCAST, 32'h0000_0080, 32'hB0B0_0001, {8'h07, 2'b01});
        drive(p); exp_q.push_back(p);
        tick();
        chk("bc_fwd_valid",   64'(RingOutValid), 64'd1);
        chk("bc_req_valid",   64'(F2cReqValid), 64'd1);
        chk("bc_req_op",      64'(F2cReqOpcode), 64'(WR));
        chk("bc_req_data",    64'(F2cReqData), 64'hB0B0_0001);
        idle(); tick();
        chk("bc_retired",     64'(F2cReqValid), 64'd0);
        // Own broadcast returning: end of lap, no local write.
        drive(mk(WR_BCAST, 32'h0000_0084, 32'hB0B0_0002, {8'h03, 2'b10}));
        tick();
        chk("bc_own_consumed", 64'(RingOutValid), 64'd0);
        chk("bc_own_no_req",   64'(F2cReqValid), 64'd0);
        idle(); tick();

        // Contention: a ready response waits for the first bubble.
        rd_data_q.push_back(32'h5555_AAAA);
        drive(mk(RD, 32'h0300_0200, 32'h0, 10'h031));
        tick();
        for (int i = 0; i < 8; i++) begin
            p = mk(RD, 32'h0500_0300 + 32'(4 * i), 32'(i), 10'h050 + 10'(i));
            drive(p); exp_q.push_back(p);
            tick();
            chk("cont_fwd_opcode", 64'(RingOutOpcode), 64'(RD));
        end
        exp_q.push_back(mk(RD_RSP, 32'h0300_0200, 32'h5555_AAAA, 10'h031));
        idle(); tick();
        chk("cont_rsp_opcode", 64'(RingOutOpcode), 64'(RD_RSP));
        chk("cont_rsp_data",   64'(RingOutData), 64'h5555_AAAA);
        drain("cont_drain", 10);

        // Reset while a read is in flight; the late response is an orphan.
        mem_hold = 1'b1;
        drive(mk(RD, 32'h0300_0300, 32'h0, 10'h0AA));
        tick();
        idle(); tick();
        chk("rst_inflight_blocked", 64'(F2cReqValid), 64'd0);
        RstQnnnH = 1'b1;
        tick();
        RstQnnnH = 1'b0;
        chk("rst_ring_valid", 64'(RingOutValid), 64'd0);
        chk("rst_req_valid",  64'(F2cReqValid), 64'd0);
        chk("rst_rc_error",   64'(RcError), 64'd0);
        mem_hold  = 1'b0;
        force_rsp = 1'b1;
        tick();
        force_rsp = 1'b0;
        chk("orphan_err_pulse", 64'(RcError), 64'd1);
        chk("orphan_no_rsp",    64'(RingOutValid), 64'd0);
        tick();
        chk("orphan_err_once",  64'(RcError), 64'd0);
        chk("orphan_no_rsp_2",  64'(RingOutValid), 64'd0);
        tick();
        chk("orphan_no_rsp_3",  64'(RingOutValid), 64'd0);
        chk("orphan_no_req",    64'(F2cReqValid), 64'd0);

        drain("final_drain", 5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
